branch_resolve_unit: RTL and testbench



---
 rtl/bru_pkg.sv | 43 ++++
 rtl/br_target_calc.sv | 24 ++
 rtl/branch_resolve_unit.sv | 200 ++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared definitions for the ID-stage branch resolver and the jump unit:
// FSM state encoding, PC increment, offset extension and counter helpers.
package bru_pkg;

   // Resolver control states
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_REDIR = 2'd2
   } bru_state_e;

   // Byte distance between consecutive instructions
   localparam int unsigned PC_INC = 32'd4;

   // Widest address the offset helper supports
   localparam int unsigned BRU_MAX_W = 32'd64;

   // Saturation ceiling for the statistics counters
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   // Sign-extend the low imm_w bits of imm and convert the word offset to bytes.
   // The value is pushed to the top of the word, then arithmetically shifted
   // back so the original sign bit fills everything above it.
   function automatic logic [BRU_MAX_W-1:0] sext_shl2(
      input logic [BRU_MAX_W-1:0] imm,
      input int unsigned          imm_w
   );
      logic signed [BRU_MAX_W-1:0] ext;
      ext = $signed(imm << (BRU_MAX_W - imm_w));
      ext = ext >>> (BRU_MAX_W - imm_w);
      return $unsigned(ext) << 2;
   endfunction

   // Increment that sticks at the ceiling instead of wrapping
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      if (v == CNT_MAX) begin
         return v;
      end else begin
         return v + 32'd1;
      end
   endfunction

endpackage

// File: rtl/br_target_calc.sv
// Combinational branch target / fall-through adder. Target wraps modulo
// 2^ADDR_W. Shared with the jump unit, so it carries no state.
module br_target_calc
   import bru_pkg::*;
#(
   parameter int unsigned ADDR_W = 32'd32,
   parameter int unsigned IMM_W  = 32'd16
) (
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [IMM_W-1:0]  imm_i,
   output logic [ADDR_W-1:0] target_o,
   output logic [ADDR_W-1:0] fallthrough_o
);

   logic [BRU_MAX_W-1:0] offset;

   // Next-sequential address and PC-relative target of the branch in ID
   always_comb begin
      offset        = sext_shl2(BRU_MAX_W'(imm_i), IMM_W);
      fallthrough_o = pc_i + ADDR_W'(PC_INC);
      target_o      = fallthrough_o + offset[ADDR_W-1:0];
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage beq resolver: holds the IF/ID valid/PC/prediction, compares the
// forwarded operands, reports the actual outcome to the 2-bit predictor and
// redirects fetch (squashing two wrong-path fetches) on a mispredict.
// Optional build macro BR_STATS_EN adds saturating br_cnt / mispred_cnt outputs.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int unsigned ADDR_W = 32'd32,
   parameter int unsigned IMM_W  = 32'd16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   input  logic [ADDR_W-1:0] if_pc,
   input  logic              if_pred_taken,
   input  logic              id_is_beq,
   input  logic [IMM_W-1:0]  id_imm,
   input  logic [31:0]       id_rs_data,
   input  logic [31:0]       id_rt_data,
   input  logic              id_opnd_ready,
   output logic              stall_o,
   output logic              id_valid_o,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              bp_update,
   output logic              equal_or_not
`ifdef BR_STATS_EN
   ,
   output logic [31:0]       br_cnt,
   output logic [31:0]       mispred_cnt
`endif
);

   bru_state_e        state_q, state_d;
   logic              id_valid_q, id_valid_d;
   logic [ADDR_W-1:0] id_pc_q, id_pc_d;
   logic              id_pred_q, id_pred_d;
   logic              bp_update_q, bp_update_d;
   logic              equal_or_not_q, equal_or_not_d;
   logic              redirect_valid_q, redirect_valid_d;
   logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;

   logic              stall;
   logic              resolve;
   logic              actual;
   logic              mispredict;
   logic              squash;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] fallthrough;

   br_target_calc #(
      .ADDR_W (ADDR_W),
      .IMM_W  (IMM_W)
   ) u_target_calc (
      .pc_i          (id_pc_q),
      .imm_i         (id_imm),
      .target_o      (target),
      .fallthrough_o (fallthrough)
   );

   // Stall / resolve / squash decisions for the instruction held in ID
   always_comb begin
      stall      = id_valid_q & id_is_beq & ~id_opnd_ready;
      resolve    = id_valid_q & id_is_beq & id_opnd_ready & (state_q != ST_REDIR);
      actual     = (id_rs_data == id_rt_data);
      mispredict = resolve & (actual != id_pred_q);
      // First wrong-path fetch dies at the resolve edge, second at the REDIR edge
      squash     = mispredict | (state_q == ST_REDIR);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a mispredict resolved out of WAIT still needs REDIR
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (mispredict) begin
               state_d = ST_REDIR;
            end else if (stall) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_WAIT: begin
            if (mispredict) begin
               state_d = ST_REDIR;
            end else if (stall) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_REDIR: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // IF/ID capture and next values of the registered outputs
   always_comb begin
      if (stall) begin
         id_valid_d = id_valid_q;
         id_pc_d    = id_pc_q;
         id_pred_d  = id_pred_q;
      end else begin
         id_valid_d = if_valid & ~squash;
         id_pc_d    = if_pc;
         id_pred_d  = if_pred_taken;
      end

      bp_update_d      = resolve;
      redirect_valid_d = mispredict;

      if (resolve) begin
         equal_or_not_d = actual;
      end else begin
         equal_or_not_d = equal_or_not_q;
      end

      if (mispredict) begin
         redirect_pc_d = actual ? target : fallthrough;
      end else begin
         redirect_pc_d = redirect_pc_q;
      end
   end

   // IF/ID pipeline register and registered predictor/fetch outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         id_valid_q       <= 1'b0;
         id_pc_q          <= {ADDR_W{1'b0}};
         id_pred_q        <= 1'b0;
         bp_update_q      <= 1'b0;
         equal_or_not_q   <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= {ADDR_W{1'b0}};
      end else begin
         id_valid_q       <= id_valid_d;
         id_pc_q          <= id_pc_d;
         id_pred_q        <= id_pred_d;
         bp_update_q      <= bp_update_d;
         equal_or_not_q   <= equal_or_not_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   assign stall_o        = stall;
   assign id_valid_o     = id_valid_q;
   assign bp_update      = bp_update_q;
   assign equal_or_not   = equal_or_not_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

`ifdef BR_STATS_EN
   logic [31:0] br_cnt_q, br_cnt_d;
   logic [31:0] mispred_cnt_q, mispred_cnt_d;

   // Count update and redirect pulses, sticking at all-ones
   always_comb begin
      if (bp_update_q) begin
         br_cnt_d = sat_inc(br_cnt_q);
      end else begin
         br_cnt_d = br_cnt_q;
      end
      if (redirect_valid_q) begin
         mispred_cnt_d = sat_inc(mispred_cnt_q);
      end else begin
         mispred_cnt_d = mispred_cnt_q;
      end
   end

   // Statistics counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt_q      <= 32'd0;
         mispred_cnt_q <= 32'd0;
      end else begin
         br_cnt_q      <= br_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign br_cnt      = br_cnt_q;
   assign mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by
// randomized traffic, all checked against a cycle-level reference model.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic        id_is_beq;
   logic [15:0] id_imm;
   logic [31:0] id_rs_data;
   logic [31:0] id_rt_data;
   logic        id_opnd_ready;
   logic        stall_o;
   logic        id_valid_o;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        bp_update;
   logic        equal_or_not;
`ifdef BR_STATS_EN
   logic [31:0] br_cnt;
   logic [31:0] mispred_cnt;
   int unsigned m_br  = 0;
   int unsigned m_mis = 0;
`endif

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: ID slot contents, pending squash count, expected outputs
   logic        m_v   = 1'b0;
   logic [31:0] m_pc  = 32'd0;
   logic        m_pred = 1'b0;
   int          m_sq  = 0;
   logic        e_bp  = 1'b0;
   logic        e_eq  = 1'b0;
   logic        e_rv  = 1'b0;
   logic [31:0] e_rpc = 32'd0;

   always #5 clk = ~clk;

   branch_resolve_unit dut (
      .clk            (clk),
      .rst            (rst),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_pred_taken  (if_pred_taken),
      .id_is_beq      (id_is_beq),
      .id_imm         (id_imm),
      .id_rs_data     (id_rs_data),
      .id_rt_data     (id_rt_data),
      .id_opnd_ready  (id_opnd_ready),
      .stall_o        (stall_o),
      .id_valid_o     (id_valid_o),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bp_update      (bp_update),
      .equal_or_not   (equal_or_not)
`ifdef BR_STATS_EN
      ,
      .br_cnt         (br_cnt),
      .mispred_cnt    (mispred_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check stall mid-cycle, advance model, check outputs
   task automatic cyc(input logic r, input logic iv, input logic [31:0] ipc,
                      input logic ip, input logic ib, input logic [15:0] imm,
                      input logic [31:0] rs, input logic [31:0] rt, input logic rdy);
      logic        e_stall;
      logic        res;
      logic        act;
      int          off;
      logic [31:0] ft;
      logic [31:0] tgt;
      @(negedge clk);
      rst = r; if_valid = iv; if_pc = ipc; if_pred_taken = ip; id_is_beq = ib;
      id_imm = imm; id_rs_data = rs; id_rt_data = rt; id_opnd_ready = rdy;
      #1;
      e_stall = m_v & ib & ~rdy;
      chk("stall_o", 32'(stall_o), 32'(e_stall));
      res = m_v & ib & rdy;
      act = (rs == rt);
      off = $signed(imm);
      ft  = m_pc + 32'd4;
      tgt = ft + 32'(off * 4);
      @(posedge clk);
      #1;
`ifdef BR_STATS_EN
      if (r) begin
         m_br = 0; m_mis = 0;
      end else begin
         if (e_bp) m_br++;
         if (e_rv) m_mis++;
      end
`endif
      if (r) begin
         m_v = 1'b0; m_pc = 32'd0; m_pred = 1'b0; m_sq = 0;
         e_bp = 1'b0; e_eq = 1'b0; e_rv = 1'b0; e_rpc = 32'd0;
      end else begin
         e_bp = res;
         if (res) e_eq = act;
         e_rv = res & (act != m_pred);
         if (e_rv) begin
            e_rpc = act ? tgt : ft;
            m_sq  = 2;
         end
         if (!e_stall) begin
            if (m_sq > 0) begin
               m_v = 1'b0;
               m_sq--;
            end else begin
               m_v = iv;
            end
            m_pc   = ipc;
            m_pred = ip;
         end
      end
      chk("id_valid_o", 32'(id_valid_o), 32'(m_v));
      chk("bp_update", 32'(bp_update), 32'(e_bp));
      chk("equal_or_not", 32'(equal_or_not), 32'(e_eq));
      chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
      chk("redirect_pc", redirect_pc, e_rpc);
`ifdef BR_STATS_EN
      chk("br_cnt", br_cnt, m_br);
      chk("mispred_cnt", mispred_cnt, m_mis);
`endif
   endtask

   initial begin
      logic        r_r, r_iv, r_ip, r_ib, r_rdy;
      logic [31:0] r_pc, r_rs, r_rt;
      logic [15:0] r_imm;

      rst = 1'b1; if_valid = 1'b1; if_pc = 32'd0; if_pred_taken = 1'b0;
      id_is_beq = 1'b0; id_imm = 16'd0; id_rs_data = 32'd0; id_rt_data = 32'd0;
      id_opnd_ready = 1'b1;

      // Reset held two cycles while IF presents instructions
      cyc(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1);
      cyc(1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1);
      chk("rst_id_valid", 32'(id_valid_o), 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);

      // Correctly predicted taken beq
      cyc(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1);
      chk("first_capture", 32'(id_valid_o), 32'd1);
      cyc(1'b0, 1'b1, 32'h104, 1'b0, 1'b1, 16'd4, 32'd5, 32'd5, 1'b1);
      chk("ok_taken_bp", 32'(bp_update), 32'd1);
      chk("ok_taken_eq", 32'(equal_or_not), 32'd1);
      chk("ok_taken_rv", 32'(redirect_valid), 32'd0);
      chk("ok_taken_nosquash", 32'(id_valid_o), 32'd1);

      // Mispredict not-taken -> taken, backward offset
      cyc(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1);
      cyc(1'b0, 1'b1, 32'h104, 1'b0, 1'b1, 16'hFFFE, 32'd7, 32'd7, 1'b1);
      chk("mp_nt_t_rv", 32'(redirect_valid), 32'd1);
      chk("mp_nt_t_pc", redirect_pc, 32'h0000_00FC);
      chk("mp_squash1", 32'(id_valid_o), 32'd0);
      cyc(1'b0, 1'b1, 32'h108, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1);
      chk("mp_squash2", 32'(id_valid_o), 32'd0);
      cyc(1'b0, 1'b1, 32'hFC, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1);
      chk("mp_third_live", 32'(id_valid_o), 32'd1);

      // Mispredict taken -> not-taken
      cyc(1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1);
      cyc(1'b0, 1'b1, 32'h204, 1'b0, 1'b1, 16'h0010, 32'd1, 32'd2, 1'b1);
      chk("mp_t_nt_pc", redirect_pc, 32'h0000_0204);
      chk("mp_t_nt_eq", 32'(equal_or_not), 32'd0);
      cyc(1'b0, 1'b1, 32'h208, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1);
      cyc(1'b0, 1'b1, 32'h204, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1);

      // Operand stall for three cycles, ID PC must stay at 0x300
      cyc(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 32'h304 + 32'(4 * i), 1'b0, 1'b1, 16'h0008, 32'd1, 32'd2, 1'b0);
         chk("stall_no_update", 32'(bp_update), 32'd0);
      end
      cyc(1'b0, 1'b1, 32'h310, 1'b0, 1'b1, 16'h0008, 32'd1, 32'd2, 1'b1);
      chk("stall_update", 32'(bp_update), 32'd1);
      chk("stall_held_pc", redirect_pc, 32'h0000_0304);
      cyc(1'b0, 1'b1, 32'h314, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1);
      cyc(1'b0, 1'b1, 32'h304, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1);

      // Reset during REDIR, then wrap-around target without reset
      cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1);
      cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 16'd0, 32'd3, 32'd3, 1'b1);
      chk("redir_rv", 32'(redirect_valid), 32'd1);
      cyc(1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1);
      chk("rst_in_redir_rv", 32'(redirect_valid), 32'd0);
      cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1);
      chk("post_rst_live", 32'(id_valid_o), 32'd1);
      cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 16'd0, 32'd9, 32'd9, 1'b1);
      chk("wrap_rv", 32'(redirect_valid), 32'd1);
      chk("wrap_pc", redirect_pc, 32'h0000_0000);
      cyc(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1);
      cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         r_r   = ($urandom_range(0, 49) == 0);
         r_iv  = ($urandom_range(0, 9) != 0);
         r_pc  = $urandom() & 32'hFFFF_FFFC;
         if ($urandom_range(0, 7) == 0) r_pc = r_pc | 32'hFFFF_FF00;
         r_ip  = $urandom_range(0, 1) == 1;
         r_ib  = $urandom_range(0, 1) == 1;
         r_imm = 16'($urandom());
         r_rs  = $urandom();
         r_rt  = ($urandom_range(0, 1) == 1) ? r_rs : $urandom();
         r_rdy = ($urandom_range(0, 3) != 0);
         cyc(r_r, r_iv, r_pc, r_ip, r_ib, r_imm, r_rs, r_rt, r_rdy);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
